// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman keyboard front end: decoder FSM
// states, PS/2 set-2 control bytes and command encodings.
package hangman_pkg;

   // Decoder FSM states: idle, after F0, after E0, after E0 F0.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kd_state_e;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   // Command index for Enter; letters occupy 0..25.
   localparam logic [4:0] CMD_START = 5'd26;

   localparam int unsigned NUM_LETTERS = 26;

endpackage : hangman_pkg

// File: rtl/ps2_letter_map.sv
// Purely combinational lookup from a PS/2 set-2 make code to a game
// command index: A..Z -> 0..25, Enter -> 26. hit_o flags a mapped code.
module ps2_letter_map
   import hangman_pkg::*;
(
   input  logic [7:0] code_i,
   output logic [4:0] idx_o,
   output logic       hit_o
);

   // Decode table; anything not listed is an unmapped key.
   always_comb begin
      idx_o = 5'd0;
      hit_o = 1'b1;
      case (code_i)
         8'h1C:    idx_o = 5'd0;   // A
         8'h32:    idx_o = 5'd1;   // B
         8'h21:    idx_o = 5'd2;   // C
         8'h23:    idx_o = 5'd3;   // D
         8'h24:    idx_o = 5'd4;   // E
         8'h2B:    idx_o = 5'd5;   // F
         8'h34:    idx_o = 5'd6;   // G
         8'h33:    idx_o = 5'd7;   // H
         8'h43:    idx_o = 5'd8;   // I
         8'h3B:    idx_o = 5'd9;   // J
         8'h42:    idx_o = 5'd10;  // K
         8'h4B:    idx_o = 5'd11;  // L
         8'h3A:    idx_o = 5'd12;  // M
         8'h31:    idx_o = 5'd13;  // N
         8'h44:    idx_o = 5'd14;  // O
         8'h4D:    idx_o = 5'd15;  // P
         8'h15:    idx_o = 5'd16;  // Q
         8'h2D:    idx_o = 5'd17;  // R
         8'h1B:    idx_o = 5'd18;  // S
         8'h2C:    idx_o = 5'd19;  // T
         8'h3C:    idx_o = 5'd20;  // U
         8'h2A:    idx_o = 5'd21;  // V
         8'h1D:    idx_o = 5'd22;  // W
         8'h22:    idx_o = 5'd23;  // X
         8'h35:    idx_o = 5'd24;  // Y
         8'h1A:    idx_o = 5'd25;  // Z
         SC_ENTER: idx_o = CMD_START;
         default: begin
            idx_o = 5'd0;
            hit_o = 1'b0;
         end
      endcase
   end

endmodule : ps2_letter_map

// File: rtl/key_decoder.sv
// PS/2 scan-code stream to guess-command decoder. Filters break codes,
// extended-key sequences, typematic repeats and stalled prefixes so that
// each physical key press yields at most one registered load pulse.
// Optional feature macro: GUESS_LOCK_EN -- suppresses letters already
// guessed since the last start command.
module key_decoder
   import hangman_pkg::*;
#(
   parameter int unsigned TIMEOUT = 100000
)
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       scan_valid,
   input  logic [7:0] scan_code,
   output logic       load,
   output logic [4:0] load_x,
   output logic       key_held
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   kd_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       held_code_q, held_code_d;
   logic             key_held_q, key_held_d;
   logic             load_q, load_d;
   logic [4:0]       load_x_q, load_x_d;

   logic [4:0]       map_idx_s;
   logic             map_hit_s;
   logic             tmo_hit_s;
   logic             is_prefix_s;
   logic             make_s;
   logic             brk_s;
   logic             repeat_s;
   logic             locked_s;

   ps2_letter_map u_map (
      .code_i (scan_code),
      .idx_o  (map_idx_s),
      .hit_o  (map_hit_s)
   );

   assign tmo_hit_s   = (state_q != ST_IDLE) && (cnt_q == TMO_LAST);
   assign is_prefix_s = (scan_code == SC_BREAK) || (scan_code == SC_EXT);
   assign make_s      = scan_valid && (state_q == ST_IDLE) && !is_prefix_s;
   assign brk_s       = scan_valid && (state_q == ST_BRK);
   assign repeat_s    = key_held_q && (scan_code == held_code_q);

`ifdef GUESS_LOCK_EN
   logic [NUM_LETTERS-1:0] used_q, used_d;
   logic [NUM_LETTERS-1:0] letter_bit_s;

   // One-hot of the mapped letter; Enter (26) shifts out to all zeros.
   assign letter_bit_s = 26'd1 << map_idx_s;
   assign locked_s     = |(used_q & letter_bit_s);

   // Guessed-letter mask register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         used_q <= 26'd0;
      end else begin
         used_q <= used_d;
      end
   end
`else
   assign locked_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a received byte always takes priority over expiry.
   always_comb begin
      state_d = state_q;
      if (scan_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == SC_BREAK) begin
                  state_d = ST_BRK;
               end else if (scan_code == SC_EXT) begin
                  state_d = ST_EXT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_BRK:  state_d = ST_IDLE;
            ST_EXT: begin
               if (scan_code == SC_BREAK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_EXT_BRK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end else if (tmo_hit_s) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // Prefix timeout counter: runs only while waiting in a prefix state and
   // saturates at its terminal value instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (scan_valid || (state_q == ST_IDLE)) begin
         cnt_d = '0;
      end else if (cnt_q == TMO_LAST) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Output/datapath logic: make, repeat and break handling.
   always_comb begin
      load_d      = 1'b0;
      load_x_d    = load_x_q;
      held_code_d = held_code_q;
      key_held_d  = key_held_q;
`ifdef GUESS_LOCK_EN
      used_d      = used_q;
`endif
      if (make_s) begin
         if (repeat_s) begin
            key_held_d = key_held_q;
         end else begin
            held_code_d = scan_code;
            key_held_d  = 1'b1;
            if (map_hit_s && !locked_s) begin
               load_d   = 1'b1;
               load_x_d = map_idx_s;
`ifdef GUESS_LOCK_EN
               if (map_idx_s == CMD_START) begin
                  used_d = 26'd0;
               end else begin
                  used_d = used_q | letter_bit_s;
               end
`endif
            end else begin
               load_d = 1'b0;
            end
         end
      end else if (brk_s) begin
         if (scan_code == held_code_q) begin
            key_held_d = 1'b0;
         end else begin
            key_held_d = key_held_q;
         end
      end else begin
         load_d = 1'b0;
      end
   end

   // Registered outputs, hold tracking and timeout counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q       <= '0;
         held_code_q <= 8'h00;
         key_held_q  <= 1'b0;
         load_q      <= 1'b0;
         load_x_q    <= 5'd0;
      end else begin
         cnt_q       <= cnt_d;
         held_code_q <= held_code_d;
         key_held_q  <= key_held_d;
         load_q      <= load_d;
         load_x_q    <= load_x_d;
      end
   end

   assign load     = load_q;
   assign load_x   = load_x_q;
   assign key_held = key_held_q;

endmodule : key_decoder

// File: tb/tb_key_decoder.sv
// Directed self-checking bench for key_decoder (short TIMEOUT).
module tb_key_decoder;

   localparam int TB_TMO = 8;
`ifdef GUESS_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic       clk;
   logic       resetn;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       load;
   logic [4:0] load_x;
   logic       key_held;

   int checks;
   int errors;
   int pulse_cnt;
   int exp_pulses;

   key_decoder #(.TIMEOUT(TB_TMO)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .scan_valid (scan_valid),
      .scan_code  (scan_code),
      .load       (load),
      .load_x     (load_x),
      .key_held   (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every high cycle of load to catch stretched or extra pulses.
   always @(negedge clk) begin
      if (load === 1'b1) pulse_cnt++;
   end

   // Strobe one byte for one cycle and sample outputs the cycle after.
   task automatic drive(input logic [7:0] b, output logic ld,
                        output logic [4:0] lx, output logic kh);
      @(negedge clk);
      scan_valid = 1'b1;
      scan_code  = b;
      @(negedge clk);
      scan_valid = 1'b0;
      ld = load;
      lx = load_x;
      kh = key_held;
   endtask

   task automatic test_reset;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (load !== 1'b0 || load_x !== 5'd0 || key_held !== 1'b0) begin
         errors++;
         $display("FAIL reset: got load=%b x=%0d held=%b required 0 0 0",
                  load, load_x, key_held);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
      logic       el  [3] = '{1'b1, 1'b0, 1'b0};
      logic       ek  [3] = '{1'b1, 1'b1, 1'b0};
      logic ld, kh; logic [4:0] lx;
      for (int i = 0; i < 3; i++) begin
         drive(seq[i], ld, lx, kh);
         exp_pulses += int'(el[i]);
         checks++;
         if (ld !== el[i] || kh !== ek[i] || (el[i] && lx !== 5'd0)) begin
            errors++;
            $display("FAIL basic[%0d]: got load=%b x=%0d held=%b required %b 0 %b",
                     i, ld, lx, kh, el[i], ek[i]);
         end
      end
   endtask

   task automatic test_repeat;
      logic [7:0] seq [6] = '{8'h1A, 8'h1A, 8'h1A, 8'hF0, 8'h1A, 8'h1A};
      logic       el  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, !LOCK};
      logic       ek  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic ld, kh; logic [4:0] lx;
      for (int i = 0; i < 6; i++) begin
         drive(seq[i], ld, lx, kh);
         exp_pulses += int'(el[i]);
         checks++;
         if (ld !== el[i] || kh !== ek[i] || (el[i] && lx !== 5'd25)) begin
            errors++;
            $display("FAIL repeat[%0d]: got load=%b x=%0d held=%b required %b 25 %b",
                     i, ld, lx, kh, el[i], ek[i]);
         end
      end
   endtask

   task automatic test_letter_map;
      logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
         8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44,
         8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
         8'h35, 8'h1A};
      logic ld, kh; logic [4:0] lx;
      // Start command first so a lock mask, if present, is clear.
      drive(8'h5A, ld, lx, kh);
      exp_pulses++;
      checks++;
      if (ld !== 1'b1 || lx !== 5'd26) begin
         errors++;
         $display("FAIL map_start: got load=%b x=%0d required 1 26", ld, lx);
      end
      drive(8'hF0, ld, lx, kh);
      drive(8'h5A, ld, lx, kh);
      for (int i = 0; i < 26; i++) begin
         drive(codes[i], ld, lx, kh);
         exp_pulses++;
         checks++;
         if (ld !== 1'b1 || lx !== 5'(i)) begin
            errors++;
            $display("FAIL map[%0d]: got load=%b x=%0d required 1 %0d", i, ld, lx, i);
         end
         drive(8'hF0, ld, lx, kh);
         drive(codes[i], ld, lx, kh);
      end
      // Unmapped make ('1' key) is tracked but silent.
      drive(8'h16, ld, lx, kh);
      checks++;
      if (ld !== 1'b0 || kh !== 1'b1) begin
         errors++;
         $display("FAIL map_unmapped: got load=%b held=%b required 0 1", ld, kh);
      end
      drive(8'hF0, ld, lx, kh);
      drive(8'h16, ld, lx, kh);
   endtask

   task automatic test_extended;
      logic [7:0] seq [6] = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'h5A};
      logic       el  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic ld, kh; logic [4:0] lx;
      for (int i = 0; i < 6; i++) begin
         drive(seq[i], ld, lx, kh);
         exp_pulses += int'(el[i]);
         checks++;
         if (ld !== el[i] || (el[i] && lx !== 5'd26)) begin
            errors++;
            $display("FAIL ext[%0d]: got load=%b x=%0d required %b 26", i, ld, lx, el[i]);
         end
      end
   endtask

   task automatic test_timeout;
      logic ld, kh; logic [4:0] lx;
      // Stalled F0: after expiry, 24 is a fresh make of E.
      drive(8'hF0, ld, lx, kh);
      repeat (TB_TMO + 2) @(negedge clk);
      drive(8'h24, ld, lx, kh);
      exp_pulses++;
      checks++;
      if (ld !== 1'b1 || lx !== 5'd4 || kh !== 1'b1) begin
         errors++;
         $display("FAIL timeout_make: got load=%b x=%0d held=%b required 1 4 1", ld, lx, kh);
      end
      // Byte arriving in the expiry cycle is still a break.
      drive(8'hF0, ld, lx, kh);
      repeat (TB_TMO - 2) @(negedge clk);
      drive(8'h24, ld, lx, kh);
      checks++;
      if (ld !== 1'b0 || kh !== 1'b0) begin
         errors++;
         $display("FAIL timeout_edge: got load=%b held=%b required 0 0", ld, kh);
      end
      // One cycle later the prefix has been abandoned.
      drive(8'hF0, ld, lx, kh);
      repeat (TB_TMO - 1) @(negedge clk);
      drive(8'h2C, ld, lx, kh);
      exp_pulses++;
      checks++;
      if (ld !== 1'b1 || lx !== 5'd19) begin
         errors++;
         $display("FAIL timeout_late: got load=%b x=%0d required 1 19", ld, lx);
      end
   endtask

   task automatic test_back_to_back;
      logic ld1, ld2, ld3; logic [4:0] lx1, lx2;
      @(negedge clk);
      scan_valid = 1'b1;
      scan_code  = 8'h1D;
      @(negedge clk);
      scan_code  = 8'h22;
      ld1 = load; lx1 = load_x;
      @(negedge clk);
      scan_valid = 1'b0;
      ld2 = load; lx2 = load_x;
      @(negedge clk);
      ld3 = load;
      exp_pulses += 2;
      checks++;
      if (ld1 !== 1'b1 || lx1 !== 5'd22 || ld2 !== 1'b1 || lx2 !== 5'd23 || ld3 !== 1'b0) begin
         errors++;
         $display("FAIL b2b: got %b/%0d %b/%0d %b required 1/22 1/23 0",
                  ld1, lx1, ld2, lx2, ld3);
      end
   endtask

   task automatic test_reset_mid;
      logic ld, kh; logic [4:0] lx;
      drive(8'hF0, ld, lx, kh);
      resetn = 1'b0;
      #1;
      checks++;
      if (load !== 1'b0 || load_x !== 5'd0 || key_held !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got load=%b x=%0d held=%b required 0 0 0",
                  load, load_x, key_held);
      end
      @(negedge clk);
      resetn = 1'b1;
      drive(8'h2B, ld, lx, kh);
      exp_pulses++;
      checks++;
      if (ld !== 1'b1 || lx !== 5'd5) begin
         errors++;
         $display("FAIL reset_next: got load=%b x=%0d required 1 5", ld, lx);
      end
   endtask

   task automatic test_lock;
      logic [7:0] seq [8] = '{8'h32, 8'hF0, 8'h32, 8'h32, 8'h5A, 8'hF0, 8'h5A, 8'h32};
      logic       el  [8] = '{1'b1, 1'b0, 1'b0, !LOCK, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [4:0] ex  [8] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd26, 5'd0, 5'd0, 5'd1};
      logic ld, kh; logic [4:0] lx;
      for (int i = 0; i < 8; i++) begin
         drive(seq[i], ld, lx, kh);
         exp_pulses += int'(el[i]);
         checks++;
         if (ld !== el[i] || (el[i] && lx !== ex[i])) begin
            errors++;
            $display("FAIL lock[%0d]: got load=%b x=%0d required %b %0d",
                     i, ld, lx, el[i], ex[i]);
         end
      end
   endtask

   task automatic test_pulse_total;
      repeat (2) @(negedge clk);
      checks++;
      if (pulse_cnt != exp_pulses) begin
         errors++;
         $display("FAIL pulse_total: got %0d required %0d", pulse_cnt, exp_pulses);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      pulse_cnt  = 0;
      exp_pulses = 0;
      scan_valid = 1'b0;
      scan_code  = 8'h00;
      test_reset();
      test_basic();
      test_repeat();
      test_letter_map();
      test_extended();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_lock();
      test_pulse_total();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_key_decoder

// File: doc/key_decoder.md
# key_decoder

- Turns the PS/2 scan-code byte stream from the keyboard receiver into the guess commands consumed by `game_handler`.
- Emits a one-cycle `load` pulse with `load_x` = 0..25 for letters A..Z and 26 for Enter (start game).
- Removes break codes, extended-key traffic, typematic auto-repeat and stalled prefixes, so the game sees exactly one command per physical key press.

## Interface
Parameters:
- `TIMEOUT`, 100000, clock cycles a prefix state may wait for its next byte before abandoning the sequence; minimum 2.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `scan_valid`  in  1  one-cycle strobe: `scan_code` holds a received byte.
- `scan_code`  in  8  scan-code set 2 byte.
- `load`  out  1  one-cycle command strobe to `game_handler`.
- `load_x`  out  5  command: 0..25 = letter A..Z, 26 = start; valid only while `load`=1.
- `key_held`  out  1  a non-extended make has been accepted and its break not yet seen.

## Operation
- FSM states:
  - IDLE: waiting for a make or prefix byte.
  - BRK: after F0.
  - EXT: after E0.
  - EXT_BRK: after E0 F0.
- Transitions, on `scan_valid` only:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make, stay IDLE.
  - BRK: any byte is a break code -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, ignored.
  - EXT_BRK: any byte -> IDLE, ignored.
- Make handling in IDLE, byte b:
  - If b equals `held_code` and `key_held`=1: typematic repeat, no output.
  - Otherwise `held_code`<=b and `key_held`<=1.
  - If b maps, `load`=1 and `load_x`=map(b).
  - Unmapped makes update `held_code` but produce no `load`.
- Break handling in BRK, byte b: if b equals `held_code`, `key_held`<=0; otherwise no change.
- Letter map (hex):
  - A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42
  - L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A
  - W1D X22 Y35 Z1A
  - Enter 5A -> 26.
- Extended codes never produce `load`, including keypad Enter E0 5A.
- Timeout:
  - Counter cleared on every `scan_valid` and in IDLE; increments in BRK/EXT/EXT_BRK.
  - On reaching `TIMEOUT-1`, return to IDLE next cycle with no output and `held_code` untouched.
  - Counter width `$clog2(TIMEOUT)`; must not wrap.
- Simultaneous events:
  - `scan_valid` in the same cycle as timeout expiry: the byte is processed in the current state; the byte wins.
  - `scan_valid` during an output cycle: processed normally; back-to-back `load` pulses are legal.

## Timing
- Latency: `load` asserts exactly one cycle after the `scan_valid` cycle carrying the qualifying make; output registered.
- `load` is high for exactly one cycle per accepted command. There is no ready/backpressure; the consumer must sample every pulse.
- Reset values (async on `resetn`=0):
  - `load`=0, `load_x`=0, `key_held`=0.
  - State IDLE, `held_code`=00, timeout counter 0.
  - Lock mask 0 when `GUESS_LOCK_EN` is defined.
- Reset mid-sequence (e.g. after F0) discards the prefix; the first byte after release is treated as from IDLE.

## Configuration
- `GUESS_LOCK_EN` defined:
  - Adds a 26-bit `used` register.
  - A letter make whose `used` bit is set produces no `load`; `held_code`/`key_held` still update.
  - Emitting a letter sets its bit.
  - Emitting start (26) clears all bits in the same cycle the pulse is registered. Start is never locked.
- `GUESS_LOCK_EN` undefined: no `used` register; every non-repeat mapped make emits, and duplicate-guess handling is left to `game_handler`.

## Structure
- Shared package `hangman_pkg`:
  - FSM state typedef.
  - Byte constants `SC_BREAK`=F0, `SC_EXT`=E0, `SC_ENTER`=5A.
  - `CMD_START`=5'd26.
  - Letter-count constant 26.
- One combinational sub-module `ps2_letter_map`: 8-bit code in; 5-bit index and `hit` out.
- FSM, timeout counter, hold tracking and optional lock stay in `key_decoder`.

## Test plan
- Reset, then bytes 1C, F0, 1C -> one `load` with `load_x`=0 one cycle after the 1C strobe; `key_held` 1 then 0 after the break.
- Bytes 1A, 1A, 1A, F0, 1A, 1A -> exactly two pulses, both `load_x`=25.
- Bytes E0, 5A, E0, F0, 5A then 5A -> only the final 5A yields `load_x`=26.
- F0 then no byte for `TIMEOUT` cycles, then 24 -> state back in IDLE; 24 emits `load_x`=4 rather than being taken as a break.
- With `GUESS_LOCK_EN`:
  - 32, F0, 32, 32 -> one `load_x`=1.
  - Then 5A, F0, 5A, 32 -> pulses 26 then 1.
- Drop `resetn` for one cycle right after an F0 -> outputs 0 immediately; the next byte 2B emits `load_x`=5.
